// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the pipelined multiply-accumulate datapath.
// Helpers work on a fixed maximum word width; callers pass the live widths and slice the result.
package mac_pkg;

  localparam int MAC_MAX_W = 64;

  typedef logic [MAC_MAX_W-1:0] mac_word_t;

  typedef struct packed {
    mac_word_t sum;
    logic      ovf;
  } mac_add_t;

  // Widen a prod_w-bit product, replicating its top bit when signed.
  function automatic mac_word_t mac_extend(input mac_word_t prod,
                                           input int        prod_w,
                                           input logic      is_signed);
    mac_word_t r;
    r = '0;
    for (int i = 0; i < MAC_MAX_W; i++) begin
      r[i] = (i < prod_w) ? prod[i] : (is_signed & prod[prod_w-1]);
    end
    return r;
  endfunction

  // acc_w-bit add of a and b; reports overflow and optionally clamps to the range limit.
  function automatic mac_add_t mac_sat_add(input mac_word_t a,
                                           input mac_word_t b,
                                           input int        acc_w,
                                           input logic      is_signed,
                                           input logic      saturate);
    mac_add_t  r;
    mac_word_t mask;
    mac_word_t raw;
    mac_word_t wrapped;
    mac_word_t sat_val;
    logic      ovf;
    mask    = (mac_word_t'(1) << acc_w) - mac_word_t'(1);
    raw     = (a & mask) + (b & mask);
    wrapped = raw & mask;
    if (is_signed) begin
      ovf     = (a[acc_w-1] == b[acc_w-1]) && (wrapped[acc_w-1] != a[acc_w-1]);
      sat_val = a[acc_w-1] ? (mac_word_t'(1) << (acc_w - 1)) : (mask >> 1);
    end else begin
      ovf     = raw[acc_w];
      sat_val = mask;
    end
    r.sum = (saturate && ovf) ? sat_val : wrapped;
    r.ovf = ovf;
    return r;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered N x N multiplier: one-cycle latency, one product per cycle, no backpressure.
// clear drops the sample on the same edge and invalidates any held product.
module mac_mult_stage #(
  parameter int N      = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             clear,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [2*N-1:0]   prod_q,
  output logic             p_valid
);

  localparam int PROD_W = 2 * N;

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;

  // The low 2N bits of the widened product are correct for both signed and unsigned operands.
  assign a_ext = (SIGNED != 0) ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
  assign b_ext = (SIGNED != 0) ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q  <= '0;
      p_valid <= 1'b0;
    end else if (clear) begin
      p_valid <= 1'b0;
    end else if (in_valid) begin
      prod_q  <= prod;
      p_valid <= 1'b1;
    end else begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage pipelined MAC: product registered, then accumulated; A*B appears two edges after it is driven.
// One term per cycle, bubbles via in_valid, no backpressure; optional DOT_LEN-term windows pulse done.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int N        = 4,
  parameter int ACC_W    = 8,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0,
  parameter int DOT_LEN  = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic                          clear,
  input  logic [N-1:0]                  A,
  input  logic [N-1:0]                  B,
  output logic [ACC_W-1:0]              accumulator,
  output logic                          acc_valid,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(DOT_LEN+2)-1:0]  count
);

  localparam int PROD_W = 2 * N;
  localparam int CNT_W  = $clog2(DOT_LEN + 2);
  localparam logic [CNT_W-1:0] DOT_LEN_C = CNT_W'(DOT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (ACC_W < 2 * N) begin : g_acc_too_narrow
    $error("mac_pipe: ACC_W must be at least 2*N");
  end
  if (ACC_W >= MAC_MAX_W) begin : g_acc_too_wide
    $error("mac_pipe: ACC_W exceeds the helper word width");
  end

  logic [PROD_W-1:0] prod_q;
  logic              p_valid;

  mac_mult_stage #(
    .N      (N),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .clear    (clear),
    .a        (A),
    .b        (B),
    .prod_q   (prod_q),
    .p_valid  (p_valid)
  );

  // Set after reset, clear or a completed window: the next term starts from zero.
  logic             win_start;
  mac_word_t        ext_w;
  mac_add_t         add_r;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] next_acc;
  logic [CNT_W-1:0] next_cnt;
  logic             next_done;
  logic             next_ovf;
  logic             unused_sum;

  always_comb begin
    ext_w     = mac_extend(mac_word_t'(prod_q), PROD_W, SIGNED != 0);
    base      = win_start ? '0 : accumulator;
    add_r     = mac_sat_add(mac_word_t'(base), ext_w, ACC_W, SIGNED != 0, SATURATE != 0);
    next_acc  = add_r.sum[ACC_W-1:0];
    next_ovf  = add_r.ovf | (overflow & ~win_start);
    next_cnt  = count;
    if (win_start) begin
      next_cnt = CNT_ONE;
    end else if (DOT_LEN > 0) begin
      next_cnt = count + CNT_ONE;
    end else if (count != CNT_MAX) begin
      next_cnt = count + CNT_ONE;
    end
    next_done = (DOT_LEN > 0) && (next_cnt == DOT_LEN_C);
  end

  assign unused_sum = ^add_r.sum[MAC_MAX_W-1:ACC_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accumulator <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      acc_valid   <= 1'b0;
      done        <= 1'b0;
      win_start   <= 1'b1;
    end else if (clear) begin
      accumulator <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      acc_valid   <= 1'b0;
      done        <= 1'b0;
      win_start   <= 1'b1;
    end else if (p_valid) begin
      accumulator <= next_acc;
      count       <= next_cnt;
      overflow    <= next_ovf;
      acc_valid   <= 1'b1;
      done        <= next_done;
      win_start   <= next_done;
    end else begin
      acc_valid   <= 1'b0;
      done        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: four configurations share one stimulus stream, each test checks its own instance.
module tb_mac_pipe;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       in_valid = 1'b0;
  logic       clear    = 1'b0;
  logic [3:0] A        = 4'd0;
  logic [3:0] B        = 4'd0;

  logic [7:0] acc_f, acc_d, acc_s, acc_g;
  logic       av_f, av_d, av_s, av_g;
  logic       dn_f, dn_d, dn_s, dn_g;
  logic       ov_f, ov_d, ov_s, ov_g;
  logic [0:0] cnt_f, cnt_s, cnt_g;
  logic [2:0] cnt_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_pipe #(.N(4), .ACC_W(8), .SIGNED(0), .SATURATE(0), .DOT_LEN(0)) u_free (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc_f), .acc_valid(av_f), .done(dn_f), .overflow(ov_f), .count(cnt_f));

  mac_pipe #(.N(4), .ACC_W(8), .SIGNED(0), .SATURATE(0), .DOT_LEN(3)) u_dot (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc_d), .acc_valid(av_d), .done(dn_d), .overflow(ov_d), .count(cnt_d));

  mac_pipe #(.N(4), .ACC_W(8), .SIGNED(0), .SATURATE(1), .DOT_LEN(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc_s), .acc_valid(av_s), .done(dn_s), .overflow(ov_s), .count(cnt_s));

  mac_pipe #(.N(4), .ACC_W(8), .SIGNED(1), .SATURATE(1), .DOT_LEN(0)) u_ssat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .clear(clear), .A(A), .B(B),
    .accumulator(acc_g), .acc_valid(av_g), .done(dn_g), .overflow(ov_g), .count(cnt_g));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic v);
    A        = a;
    B        = b;
    in_valid = v;
  endtask

  task automatic do_clear();
    drive(4'd0, 4'd0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom));
      tick();
      checks++;
      if (acc_f !== 8'd0 || acc_d !== 8'd0 || acc_s !== 8'd0 || acc_g !== 8'd0 ||
          cnt_f !== 1'b0 || cnt_d !== 3'd0 || cnt_s !== 1'b0 || cnt_g !== 1'b0 ||
          ov_f !== 1'b0 || ov_d !== 1'b0 || ov_s !== 1'b0 || ov_g !== 1'b0 ||
          dn_f !== 1'b0 || dn_d !== 1'b0 || dn_s !== 1'b0 || dn_g !== 1'b0 ||
          av_f !== 1'b0 || av_d !== 1'b0 || av_s !== 1'b0 || av_g !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: acc f/d/s/g=%0d/%0d/%0d/%0d cnt_d=%0d ov=%b%b%b%b dn=%b%b%b%b av=%b%b%b%b, expected all 0",
                 i, acc_f, acc_d, acc_s, acc_g, cnt_d, ov_f, ov_d, ov_s, ov_g,
                 dn_f, dn_d, dn_s, dn_g, av_f, av_d, av_s, av_g);
      end
    end
    drive(4'd0, 4'd0, 1'b0);
    #2 reset_n = 1'b1;
    tick();
    drive(4'd2, 4'd3, 1'b1);
    tick();
    drive(4'd0, 4'd0, 1'b0);
    tick();
    checks++;
    if (acc_f !== 8'd6) begin
      errors++;
      $display("FAIL reset_pre_async: accumulator=%0d expected 6", acc_f);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (acc_f !== 8'd0 || av_f !== 1'b0 || cnt_f !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: accumulator=%0d acc_valid=%b count=%0d expected 0/0/0", acc_f, av_f, cnt_f);
    end
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    do_clear();
    drive(4'd2, 4'd3, 1'b1);
    tick();
    drive(4'd0, 4'd0, 1'b0);
    checks++;
    if (acc_f !== 8'd0 || av_f !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge1: accumulator=%0d acc_valid=%b expected 0/0", acc_f, av_f);
    end
    tick();
    checks++;
    if (acc_f !== 8'd6 || av_f !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge2: accumulator=%0d acc_valid=%b expected 6/1", acc_f, av_f);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (acc_f !== 8'd6 || av_f !== 1'b0) begin
        errors++;
        $display("FAIL latency_hold %0d: accumulator=%0d acc_valid=%b expected 6/0", i, acc_f, av_f);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [5] = '{4'd13, 4'd7, 4'd3, 4'd0, 4'd10};
    logic [3:0] tb [5] = '{4'd4,  4'd3, 4'd6, 4'd0, 4'd5};
    logic       tv [5] = '{1'b1,  1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] ex [5] = '{8'd52, 8'd73, 8'd91, 8'd91, 8'd141};
    do_clear();
    for (int t = 0; t < 6; t++) begin
      if (t < 5) drive(ta[t], tb[t], tv[t]);
      else       drive(4'd0, 4'd0, 1'b0);
      tick();
      if (t >= 1) begin
        checks++;
        if (acc_f !== ex[t-1] || av_f !== tv[t-1] || dn_f !== 1'b0) begin
          errors++;
          $display("FAIL back_to_back slot %0d: accumulator=%0d acc_valid=%b done=%b expected %0d/%b/0",
                   t - 1, acc_f, av_f, dn_f, ex[t-1], tv[t-1]);
        end
      end
    end
  endtask

  task automatic test_dot_len();
    logic [3:0] ta [4] = '{4'd2, 4'd4, 4'd1, 4'd10};
    logic [3:0] tb [4] = '{4'd3, 4'd5, 4'd1, 4'd5};
    logic [7:0] ex [4] = '{8'd6, 8'd26, 8'd27, 8'd50};
    logic [2:0] ec [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
    logic       ed [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_clear();
    for (int t = 0; t < 5; t++) begin
      if (t < 4) drive(ta[t], tb[t], 1'b1);
      else       drive(4'd0, 4'd0, 1'b0);
      tick();
      if (t >= 1) begin
        checks++;
        if (acc_d !== ex[t-1] || cnt_d !== ec[t-1] || dn_d !== ed[t-1] || av_d !== 1'b1) begin
          errors++;
          $display("FAIL dot_len term %0d: accumulator=%0d count=%0d done=%b acc_valid=%b expected %0d/%0d/%b/1",
                   t - 1, acc_d, cnt_d, dn_d, av_d, ex[t-1], ec[t-1], ed[t-1]);
        end
      end
    end
    tick();
    checks++;
    if (acc_d !== 8'd50 || cnt_d !== 3'd1 || dn_d !== 1'b0 || av_d !== 1'b0) begin
      errors++;
      $display("FAIL dot_len_hold: accumulator=%0d count=%0d done=%b acc_valid=%b expected 50/1/0/0",
               acc_d, cnt_d, dn_d, av_d);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    drive(4'd15, 4'd15, 1'b1);
    tick();
    tick();
    drive(4'd0, 4'd0, 1'b0);
    checks++;
    if (acc_f !== 8'd225 || ov_f !== 1'b0 || acc_s !== 8'd225 || ov_s !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: wrap=%0d/%b sat=%0d/%b expected 225/0 225/0", acc_f, ov_f, acc_s, ov_s);
    end
    tick();
    checks++;
    if (acc_f !== 8'd194 || ov_f !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap: accumulator=%0d overflow=%b expected 194/1", acc_f, ov_f);
    end
    checks++;
    if (acc_s !== 8'd255 || ov_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sat: accumulator=%0d overflow=%b expected 255/1", acc_s, ov_s);
    end
    tick();
    checks++;
    if (acc_f !== 8'd194 || ov_f !== 1'b1 || ov_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: accumulator=%0d overflow=%b sat_overflow=%b expected 194/1/1", acc_f, ov_f, ov_s);
    end
    do_clear();
    drive(4'd8, 4'd8, 1'b1);
    tick();
    tick();
    drive(4'd0, 4'd0, 1'b0);
    checks++;
    if (acc_g !== 8'd64 || ov_g !== 1'b0) begin
      errors++;
      $display("FAIL ovf_signed_first: accumulator=%0d overflow=%b expected 64/0", acc_g, ov_g);
    end
    tick();
    checks++;
    if (acc_g !== 8'd127 || ov_g !== 1'b1) begin
      errors++;
      $display("FAIL ovf_signed_sat: accumulator=%0d overflow=%b expected 127/1", acc_g, ov_g);
    end
  endtask

  task automatic test_clear();
    do_clear();
    drive(4'd15, 4'd15, 1'b1);
    tick();
    tick();
    drive(4'd3, 4'd3, 1'b1);
    tick();
    checks++;
    if (acc_f !== 8'd194 || ov_f !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: accumulator=%0d overflow=%b expected 194/1", acc_f, ov_f);
    end
    drive(4'd5, 4'd5, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(4'd0, 4'd0, 1'b0);
    checks++;
    if (acc_f !== 8'd0 || cnt_f !== 1'b0 || ov_f !== 1'b0 || av_f !== 1'b0 || dn_f !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: accumulator=%0d count=%0d overflow=%b acc_valid=%b done=%b expected all 0",
               acc_f, cnt_f, ov_f, av_f, dn_f);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (acc_f !== 8'd0 || av_f !== 1'b0) begin
        errors++;
        $display("FAIL clear_discard %0d: accumulator=%0d acc_valid=%b expected 0/0", i, acc_f, av_f);
      end
    end
    drive(4'd1, 4'd2, 1'b1);
    tick();
    drive(4'd0, 4'd0, 1'b0);
    tick();
    checks++;
    if (acc_f !== 8'd2 || av_f !== 1'b1 || cnt_f !== 1'b1 || ov_f !== 1'b0) begin
      errors++;
      $display("FAIL clear_next: accumulator=%0d acc_valid=%b count=%0d overflow=%b expected 2/1/1/0",
               acc_f, av_f, cnt_f, ov_f);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_dot_len();
    test_overflow();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
